mem_responder: RTL and testbench
================================

# mem_responder

Byte-bus memory/IO responder at the far end of the CPU memory interface. Answers the single-byte address/data bus driven by the CPU memory adapter and backs it with on-chip RAM. Maps a small IO window onto a UART-side TX FIFO, an RX holding register and a program-end register. Drives `io_buffer_full` back to the adapter for flow control.

## Interface
- `ADDR_WIDTH`, 17: RAM index width; RAM size is 2^ADDR_WIDTH bytes.
- `TX_DEPTH`, 8: TX FIFO depth; must be a power of two, minimum 4.
- `clk_in`  input  1  system clock.
- `rst_in`  input  1  reset; asynchronous, active-low.
- `rdy_in`  input  1  global ready; when low, the bus side is frozen.
- `mem_a`  input  32  bus address; only bits [17:0] are decoded.
- `mem_dout`  input  8  write data from the adapter.
- `mem_wr`  input  1  1 = write, 0 = read.
- `mem_din`  output  8  read data returned to the adapter.
- `io_buffer_full`  output  1  TX FIFO almost full.
- `tx_data`  output  8  TX byte at the FIFO head.
- `tx_valid`  output  1  FIFO non-empty.
- `tx_ready`  input  1  sink accepts `tx_data`.
- `rx_data`  input  8  incoming byte.
- `rx_valid`  input  1  incoming byte valid.
- `rx_ready`  output  1  RX holding register empty.
- `program_end`  output  1  sticky end-of-program flag.
- `end_code`  output  8  byte written to the end register.

## Operation
- Decode: the IO window is selected when `mem_a[17:16]` = 2'b11; all other addresses select RAM.
  - RAM index is `mem_a[ADDR_WIDTH-1:0]`.
  - IO registers are selected by `mem_a[2:0]`:
    - 0x30000 data: write pushes TX, read pops RX.
    - 0x30004 status on read; end register on write.
    - Other IO offsets read 0x00; writes to them are ignored.
- A bus cycle is every clock with `rdy_in`=1. With `rdy_in`=0 there are no RAM writes, no FIFO push, no RX pop and no end-register write, and `mem_din` holds. The `tx_*` and `rx_*` sink/source sides keep running.
- RAM write commits at the edge of the bus cycle. RAM contents are not reset.
- Data read (0x30000): returns the RX byte if the holding register is full and clears it at the same edge; returns 0x00 if empty.
- Status read (0x30004): returns {5'b0, tx_overflow, rx_full, io_buffer_full}.
- TX FIFO:
  - Push on a write to 0x30000. A push while count = TX_DEPTH drops the byte and sets sticky `tx_overflow`, which clears only on reset.
  - Pop when `tx_valid` & `tx_ready`.
  - Simultaneous push and pop leaves the count unchanged, including at full.
  - Pointers wrap modulo TX_DEPTH.
- RX register: loads `rx_data` when `rx_valid` & `rx_ready`.
  - `rx_ready` = not full, registered.
  - A pop and a load in the same cycle are not possible, since a pop requires full and a load requires empty.
- End register: a write to 0x30004 sets `program_end`=1 and loads `end_code`. Later writes update `end_code`; `program_end` stays 1.
- Reset values: `mem_din`=0, `io_buffer_full`=0, `tx_valid`=0, `tx_data`=0, `rx_ready`=1 (0 without RX), `program_end`=0, `end_code`=0, FIFO empty, `tx_overflow`=0.

## Timing
- Read latency is 1 cycle: the address is presented in cycle N and `mem_din` is valid from cycle N+1 until the next bus cycle's update.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Any IO read with `mem_wr`=0 is a read access in every bus cycle it is held. The adapter presents 0x30000 reads for exactly one bus cycle per access.
- `io_buffer_full` is registered and computed as post-update count >= TX_DEPTH-2. The 2-entry margin absorbs the adapter's one-cycle sampling lag plus one in-flight write.
- `tx_valid` and `tx_data` reflect the FIFO state registered at the previous edge. First-word latency is 1 cycle after the push edge.
- `rx_ready` deasserts the cycle after a load and reasserts the cycle after a pop.
- Reset assertion mid-transfer clears all state immediately and drops any partially written FIFO entry. Deassertion takes effect at the next edge.

## Configuration
- `MEM_RESPONDER_RX_EN`
  - Defined: RX holding register and handshake as described.
  - Undefined: no RX storage, `rx_ready` is tied 0, data reads return 0x00, and status bit 1 reads 0.

## Test plan
- Write 0xA5 to 0x00010, then read 0x00010 the next cycle -> `mem_din`=0xA5 one cycle after the read address.
- Hold `tx_ready`=0 and write 6 bytes to 0x30000 with TX_DEPTH=8:
  - `io_buffer_full` rises after the 6th write edge.
  - Write 2 more, then a 9th -> the 9th is dropped and status reads 0x05.
- `tx_ready`=1 with a write every cycle -> count stable and bytes emerge in order, each 1 cycle after its push.
- `rx_valid` with 0x3C -> `rx_ready` falls. Read 0x30000 -> `mem_din`=0x3C, and a second read -> 0x00; `rx_ready` returns high.
- Write 0x07 to 0x30004 with `rdy_in`=0 -> no effect. Repeat with `rdy_in`=1 -> `program_end`=1 and `end_code`=0x07.
- Assert `rst_in` low while the FIFO holds 3 bytes -> `tx_valid`=0 immediately and all outputs at their reset values.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Byte-bus responder for the CPU memory adapter. Backs the bus
//               with on-chip RAM and maps an IO window (mem_a[17:16] = 2'b11)
//               onto a TX FIFO, an RX holding register and an end-of-program
//               register. Optional RX path enabled by MEM_RESPONDER_RX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_end,
  output logic [7:0]  end_code
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL   = CNT_W'(TX_DEPTH);
  // Two-entry margin: adapter samples the flag one cycle late and may have
  // one more write already in flight.
  localparam logic [CNT_W-1:0] C_ALMOST = CNT_W'(TX_DEPTH - 2);

  // Address decode
  logic w_io_sel, w_io_data, w_io_stat;
  assign w_io_sel  = (mem_a[17:16] == 2'b11);
  assign w_io_data = w_io_sel && (mem_a[2:0] == 3'd0);
  assign w_io_stat = w_io_sel && (mem_a[2:0] == 3'd4);

  logic w_bus_rd, w_ram_we, w_push_req, w_push, w_pop, w_end_we;
  assign w_bus_rd   = rdy_in && !mem_wr;
  assign w_ram_we   = rdy_in && mem_wr && !w_io_sel;
  assign w_push_req = rdy_in && mem_wr && w_io_data;
  assign w_end_we   = rdy_in && mem_wr && w_io_stat;

  // State registers
  logic [7:0]       mem_din_q, mem_din_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_overflow_q, tx_overflow_d;
  logic             io_buffer_full_q, io_buffer_full_d;
  logic             program_end_q, program_end_d;
  logic [7:0]       end_code_q, end_code_d;

  // A pop at full frees a slot in the same edge, so the push is accepted.
  assign w_pop  = tx_valid_q && tx_ready;
  assign w_push = w_push_req && ((count_q != C_FULL) || w_pop);

  // Storage arrays are not reset; pointers alone define FIFO contents.
  logic [7:0] ram    [2**ADDR_WIDTH];
  logic [7:0] tx_buf [TX_DEPTH];

  // RAM write port
  always_ff @(posedge clk_in) begin
    if (w_ram_we) ram[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
  end

  // TX FIFO write port
  always_ff @(posedge clk_in) begin
    if (w_push) tx_buf[wr_ptr_q] <= mem_dout;
  end

  // RX holding register (optional)
  logic       w_rx_full;
  logic [7:0] w_rx_byte;
`ifdef MEM_RESPONDER_RX_EN
  logic       rx_full_q, rx_full_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       w_rx_load, w_rx_pop;
  assign w_rx_load = rx_valid && !rx_full_q;
  assign w_rx_pop  = w_bus_rd && w_io_data && rx_full_q;

  // RX next-state: load when empty, clear on a data read
  always_comb begin
    rx_full_d = rx_full_q;
    rx_data_d = rx_data_q;
    if (w_rx_load) begin
      rx_full_d = 1'b1;
      rx_data_d = rx_data;
    end else if (w_rx_pop) begin
      rx_full_d = 1'b0;
    end
  end

  // RX state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_full_q <= 1'b0;
      rx_data_q <= 8'h00;
    end else begin
      rx_full_q <= rx_full_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign w_rx_full = rx_full_q;
  assign w_rx_byte = rx_data_q;
  assign rx_ready  = !rx_full_q;
`else
  assign w_rx_full = 1'b0;
  assign w_rx_byte = 8'h00;
  assign rx_ready  = 1'b0;
`endif

  // Main next-state: FIFO pointers/count, flags, read data, end register
  always_comb begin
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    tx_overflow_d    = tx_overflow_q || (w_push_req && !w_push);
    program_end_d    = program_end_q;
    end_code_d       = end_code_q;
    mem_din_d        = mem_din_q;

    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (w_push && !w_pop)      count_d = count_q + 1'b1;
    else if (!w_push && w_pop) count_d = count_q - 1'b1;

    tx_valid_d       = (count_d != '0);
    io_buffer_full_d = (count_d >= C_ALMOST);
    // Head after this edge; bypass when the head slot is written right now.
    if (count_d == '0)                      tx_data_d = 8'h00;
    else if (w_push && wr_ptr_q == rd_ptr_d) tx_data_d = mem_dout;
    else                                     tx_data_d = tx_buf[rd_ptr_d];

    if (w_end_we) begin
      program_end_d = 1'b1;
      end_code_d    = mem_dout;
    end

    if (w_bus_rd) begin
      if (!w_io_sel)      mem_din_d = ram[mem_a[ADDR_WIDTH-1:0]];
      else if (w_io_data) mem_din_d = w_rx_full ? w_rx_byte : 8'h00;
      else if (w_io_stat) mem_din_d = {5'b0, tx_overflow_q, w_rx_full, io_buffer_full_q};
      else                mem_din_d = 8'h00;
    end
  end

  // Main state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din_q        <= 8'h00;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      tx_valid_q       <= 1'b0;
      tx_data_q        <= 8'h00;
      tx_overflow_q    <= 1'b0;
      io_buffer_full_q <= 1'b0;
      program_end_q    <= 1'b0;
      end_code_q       <= 8'h00;
    end else begin
      mem_din_q        <= mem_din_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      tx_valid_q       <= tx_valid_d;
      tx_data_q        <= tx_data_d;
      tx_overflow_q    <= tx_overflow_d;
      io_buffer_full_q <= io_buffer_full_d;
      program_end_q    <= program_end_d;
      end_code_q       <= end_code_d;
    end
  end

  assign mem_din        = mem_din_q;
  assign tx_valid       = tx_valid_q;
  assign tx_data        = tx_data_q;
  assign io_buffer_full = io_buffer_full_q;
  assign program_end    = program_end_q;
  assign end_code       = end_code_q;

  // Address bits above the decoded range and, without RX, the RX inputs.
  logic w_unused;
  assign w_unused = ^{mem_a[31:18], rx_data, rx_valid};

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder. Read data and TX bytes
//               are checked by monitors against expectation queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

`ifdef MEM_RESPONDER_RX_EN
  localparam bit RX = 1'b1;
`else
  localparam bit RX = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic [31:0] mem_a = '0;
  logic [7:0]  mem_dout = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        program_end;
  logic [7:0]  end_code;

  always #5 clk_in = ~clk_in;

  mem_responder #(.ADDR_WIDTH(17), .TX_DEPTH(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
    .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .program_end(program_end), .end_code(end_code)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rd_q[$];
  logic [7:0] exp_tx_q[$];
  logic rd_issue = 1'b0;
  logic rd_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_dout = d; mem_wr = 1'b1;
    @(posedge clk_in); #1;
    mem_wr = 1'b0; mem_a = '0;
  endtask

  task automatic tx_push(input logic [7:0] d);
    exp_tx_q.push_back(d);
    bus_write(32'h30000, d);
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [7:0] exp);
    mem_a = a; mem_wr = 1'b0; rd_issue = 1'b1;
    exp_rd_q.push_back(exp);
    @(posedge clk_in); #1;
    rd_issue = 1'b0; mem_a = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Tracks which edges completed a checked read; mem_din is valid after them.
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) rd_pend <= 1'b0;
    else         rd_pend <= rd_issue && rdy_in;
  end

  // Monitors: compare read data and accepted TX bytes against the queues
  always @(negedge clk_in) begin
    if (rst_in && rd_pend) begin
      if (exp_rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got 0x%0h expected none", mem_din);
      end else chk("mem_din", {24'h0, mem_din}, {24'h0, exp_rd_q.pop_front()});
    end
    if (rst_in && tx_valid && tx_ready) begin
      if (exp_tx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected: got 0x%0h expected none", tx_data);
      end else chk("tx_data", {24'h0, tx_data}, {24'h0, exp_tx_q.pop_front()});
    end
  end

  initial begin
    // Reset values
    #12;
    chk("rst_mem_din", {24'h0, mem_din}, 32'h0);
    chk("rst_ibf", {31'h0, io_buffer_full}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_rx_ready", {31'h0, rx_ready}, {31'h0, RX});
    chk("rst_program_end", {31'h0, program_end}, 32'h0);
    chk("rst_end_code", {24'h0, end_code}, 32'h0);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    idle(1);

    // RAM write then read next cycle, top of RAM, unmapped IO offset
    bus_write(32'h00010, 8'hA5);
    bus_read(32'h00010, 8'hA5);
    bus_write(32'h1FFFF, 8'h5A);
    bus_read(32'h1FFFF, 8'h5A);
    bus_read(32'h30002, 8'h00);
    bus_read(32'h00010, 8'hA5);

    // Frozen bus: mem_din holds, RAM write and end-register write ignored
    rdy_in = 1'b0;
    mem_a = 32'h1FFFF;
    idle(2);
    chk("hold_mem_din", {24'h0, mem_din}, 32'hA5);
    bus_write(32'h00010, 8'h77);
    bus_write(32'h30004, 8'h07);
    chk("frozen_program_end", {31'h0, program_end}, 32'h0);
    chk("frozen_end_code", {24'h0, end_code}, 32'h0);
    rdy_in = 1'b1;
    bus_read(32'h00010, 8'hA5);
    bus_write(32'h30004, 8'h07);
    chk("program_end", {31'h0, program_end}, 32'h1);
    chk("end_code", {24'h0, end_code}, 32'h07);
    bus_write(32'h30004, 8'h09);
    chk("end_code_upd", {24'h0, end_code}, 32'h09);
    chk("program_end_sticky", {31'h0, program_end}, 32'h1);

    // Fill the FIFO with the sink stalled
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tx_push(8'h10 + 8'(i));
      chk($sformatf("ibf_fill%0d", i + 1), {31'h0, io_buffer_full}, {31'h0, (i + 1) >= 6});
      if (i == 0) begin
        chk("first_tx_valid", {31'h0, tx_valid}, 32'h1);
        chk("first_tx_data", {24'h0, tx_data}, 32'h10);
      end
    end
    bus_write(32'h30000, 8'h18);   // dropped
    bus_read(32'h30004, 8'h05);

    // Drain: bytes must emerge in order, 0x18 must not appear
    tx_ready = 1'b1;
    idle(10);
    chk("drain_queue_empty", exp_tx_q.size(), 32'h0);
    chk("drain_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("drain_ibf", {31'h0, io_buffer_full}, 32'h0);

    // Streaming: each byte appears one cycle after its push
    for (int i = 0; i < 8; i++) begin
      tx_push(8'h40 + 8'(i));
      chk($sformatf("stream_data%0d", i), {24'h0, tx_data}, {24'h0, 8'h40 + 8'(i)});
      chk($sformatf("stream_ibf%0d", i), {31'h0, io_buffer_full}, 32'h0);
    end
    idle(3);
    chk("stream_queue_empty", exp_tx_q.size(), 32'h0);

    // RX byte: load, status, pop, empty read
    rx_data = 8'h3C; rx_valid = 1'b1;
    @(posedge clk_in); #1;
    rx_valid = 1'b0;
    chk("rx_ready_low", {31'h0, rx_ready}, 32'h0);
    bus_read(32'h30004, RX ? 8'h06 : 8'h04);
    bus_read(32'h30000, RX ? 8'h3C : 8'h00);
    bus_read(32'h30000, 8'h00);
    chk("rx_ready_back", {31'h0, rx_ready}, {31'h0, RX});

    // Asynchronous reset while the FIFO holds 3 bytes
    tx_ready = 1'b0;
    bus_write(32'h30000, 8'hB1);
    bus_write(32'h30000, 8'hB2);
    bus_write(32'h30000, 8'hB3);
    chk("pre_rst_tx_valid", {31'h0, tx_valid}, 32'h1);
    @(negedge clk_in); #2;
    rst_in = 1'b0;
    #1;
    chk("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("mid_rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("mid_rst_mem_din", {24'h0, mem_din}, 32'h0);
    chk("mid_rst_program_end", {31'h0, program_end}, 32'h0);
    chk("mid_rst_end_code", {24'h0, end_code}, 32'h0);
    chk("mid_rst_ibf", {31'h0, io_buffer_full}, 32'h0);
    chk("mid_rst_rx_ready", {31'h0, rx_ready}, {31'h0, RX});
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    idle(1);
    bus_read(32'h30004, 8'h00);
    tx_ready = 1'b1;
    idle(3);
    chk("post_rst_tx_valid", {31'h0, tx_valid}, 32'h0);

    chk("rd_queue_empty", exp_rd_q.size(), 32'h0);
    chk("tx_queue_empty", exp_tx_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
